// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequential ALU.
//   Holds the 8-bit operation codes (4-bit class in [7:4], sub-op in [3:0]),
//   the control FSM state type and a helper that flags the multi-cycle ops.
package alu_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h11;
    localparam logic [7:0] OP_SUB  = 8'h12;
    localparam logic [7:0] OP_MUL  = 8'h13;
    localparam logic [7:0] OP_DIV  = 8'h14;
    localparam logic [7:0] OP_MOD  = 8'h15;
    localparam logic [7:0] OP_AND  = 8'h21;
    localparam logic [7:0] OP_OR   = 8'h22;
    localparam logic [7:0] OP_XOR  = 8'h23;
    localparam logic [7:0] OP_INV  = 8'h24;
    localparam logic [7:0] OP_SLT  = 8'h31;
    localparam logic [7:0] OP_SLTU = 8'h32;
    localparam logic [7:0] OP_SLL  = 8'h33;
    localparam logic [7:0] OP_SRL  = 8'h34;
    localparam logic [7:0] OP_SRA  = 8'h35;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ops that run through the one-bit-per-cycle multiply/divide unit.
    function automatic logic is_iter(input logic [7:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative multiply / signed divide unit, one bit per cycle.
//   Multiply: LSB-first shift-add, low WIDTH bits of the product.
//   Divide:   restoring division on operand magnitudes, signs fixed up at the
//             end (quotient truncates toward zero, remainder follows dividend).
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   start             load operands and op; iteration begins next cycle
//   op                operation code (OP_MUL / OP_DIV / OP_MOD)
//   a, b              operands
//   done              high during the last of the WIDTH iteration cycles
//   result, dz        final result and divide-by-zero flag, valid with done
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             start,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;     // product accumulator / partial remainder
    logic [WIDTH-1:0] x;       // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] y;       // multiplicand / divisor magnitude
    logic             is_mul, is_mod, neg_q, neg_r, dz_r;

    logic [WIDTH:0]   r_sh, diff;
    logic             ge;
    logic [WIDTH-1:0] acc_n, x_n, y_n;

    // One iteration step; the last step's outputs feed the result directly so
    // the answer is ready in the same cycle as done.
    always_comb begin
        r_sh  = {acc, x[WIDTH-1]};
        diff  = r_sh - {1'b0, y};
        ge    = ~diff[WIDTH];
        acc_n = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
        x_n   = {x[WIDTH-2:0], ge};
        y_n   = y;
        if (is_mul) begin
            acc_n = acc + (x[0] ? y : '0);
            x_n   = x >> 1;
            y_n   = y << 1;
        end
    end

    // With a zero divisor every trial subtraction succeeds, so the remainder
    // ends as |a| and the sign fix-up restores a itself; only DIV is forced.
    always_comb begin
        if (is_mul)
            result = acc_n;
        else if (is_mod)
            result = neg_r ? -acc_n : acc_n;
        else if (dz_r)
            result = '1;
        else
            result = neg_q ? -x_n : x_n;
    end

    assign done = busy && (cnt == CW'(WIDTH - 1));
    assign dz   = dz_r && !is_mul;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            is_mul <= 1'b0;
            is_mod <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_r   <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            is_mul <= (op == OP_MUL);
            is_mod <= (op == OP_MOD);
            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r  <= a[WIDTH-1];
            dz_r   <= (b == '0);
            if (op == OP_MUL) begin
                x <= a;
                y <= b;
            end else begin
                x <= a[WIDTH-1] ? -a : a;
                y <= b[WIDTH-1] ? -b : b;
            end
        end else if (busy) begin
            acc <= acc_n;
            x   <= x_n;
            y   <= y_n;
            cnt <= cnt + CW'(1);
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with valid/ready handshakes on both sides.
//   Single-cycle ops complete one cycle after accept; MUL/DIV/MOD take
//   WIDTH+1 cycles through alu_muldiv when ALU_SEQ_MULDIV_EN is defined.
//   Without ALU_SEQ_MULDIV_EN those three ops behave as single-cycle ops
//   returning zero and no iterative hardware is built.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid / o_ready     request handshake (o_ready only in IDLE)
//   i_alu_op, i_a, i_b    operation code and operands, taken at accept
//   o_valid / i_ready     result handshake (o_valid only in DONE)
//   o_c, o_dz             result and divide-by-zero flag, held while in DONE
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [7:0]       i_alu_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_c,
    output logic             o_dz
);

    state_t           state;
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;

    assign accept = i_valid && o_ready;
    assign shamt  = i_b[SHW-1:0];

    // Single-cycle result, computed straight from the request and captured
    // into o_c at the accept edge.
    always_comb begin
        // NOTE: default assignment first so every path drives alu_res and no latch is inferred.
        alu_res = '0;
        case (i_alu_op)
            OP_NOP:  alu_res = '0;
            OP_ADD:  alu_res = i_a + i_b;
            OP_SUB:  alu_res = i_a - i_b;
            OP_AND:  alu_res = i_a & i_b;
            OP_OR:   alu_res = i_a | i_b;
            OP_XOR:  alu_res = i_a ^ i_b;
            OP_INV:  alu_res = ~i_a;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            OP_SLL:  alu_res = i_a << shamt;
            OP_SRL:  alu_res = i_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(i_a) >>> shamt);
            // Iterative ops are answered by alu_muldiv, or are zero when it is absent.
            OP_MUL, OP_DIV, OP_MOD: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic             md_start, md_done, md_dz;
    logic [WIDTH-1:0] md_result;

    assign md_start = accept && is_iter(i_alu_op);

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .start  (md_start),
        .op     (i_alu_op),
        .a      (i_a),
        .b      (i_b),
        .done   (md_done),
        .result (md_result),
        .dz     (md_dz)
    );
`endif

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_c     <= '0;
            o_dz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        o_ready <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
                        if (is_iter(i_alu_op)) begin
                            state <= S_BUSY;
                        end else begin
                            state   <= S_DONE;
                            o_valid <= 1'b1;
                            o_c     <= alu_res;
                            o_dz    <= 1'b0;
                        end
`else
                        state   <= S_DONE;
                        o_valid <= 1'b1;
                        o_c     <= alu_res;
                        o_dz    <= 1'b0;
`endif
                    end
                end
                S_BUSY: begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (md_done) begin
                        state   <= S_DONE;
                        o_valid <= 1'b1;
                        o_c     <= md_result;
                        o_dz    <= md_dz;
                    end
`else
                    // Unreachable without the iterative unit; recover to IDLE.
                    state   <= S_IDLE;
                    o_ready <= 1'b1;
`endif
                end
                S_DONE: begin
                    // Returning to IDLE here means no request can be taken
                    // in the same cycle the result is consumed.
                    if (i_ready) begin
                        state   <= S_IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    o_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- scoreboard bench for alu_seq (WIDTH=32).
//   Stimulus pushes the reference answer (value, dz flag, latency) into a
//   queue at accept; an independent monitor pops and compares whenever the
//   result is consumed, and checks o_ready, hold stability and latency.
//   The reference follows ALU_SEQ_MULDIV_EN the same way the design does.
module tb_alu_seq;

    localparam int W = 32;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [7:0]    i_alu_op = 8'h00;
    logic [W-1:0]  i_a = '0;
    logic [W-1:0]  i_b = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [W-1:0]  o_c;
    logic          o_dz;

    alu_seq #(.WIDTH(W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_alu_op (i_alu_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_c      (o_c),
        .o_dz     (o_dz)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] c;
        logic         dz;
        int           lat;
        int           acc_cyc;
        logic [7:0]   op;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference answer taken straight from the operation definitions.
    function automatic exp_t model(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int sa, sbv;
        sa    = a;
        sbv   = b;
        e.c   = '0;
        e.dz  = 1'b0;
        e.lat = 1;
        e.acc_cyc = 0;
        e.op  = op;
        case (op)
            8'h11: e.c = a + b;
            8'h12: e.c = a - b;
            8'h21: e.c = a & b;
            8'h22: e.c = a | b;
            8'h23: e.c = a ^ b;
            8'h24: e.c = ~a;
            8'h31: e.c = (sa < sbv) ? 1 : 0;
            8'h32: e.c = (a < b) ? 1 : 0;
            8'h33: e.c = a << b[4:0];
            8'h34: e.c = a >> b[4:0];
            8'h35: e.c = sa >>> b[4:0];
`ifdef ALU_SEQ_MULDIV_EN
            8'h13: begin e.lat = W + 1; e.c = a * b; end
            8'h14: begin
                e.lat = W + 1;
                if (b == 0) begin e.c = '1; e.dz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.c = a;
                else e.c = sa / sbv;
            end
            8'h15: begin
                e.lat = W + 1;
                if (b == 0) begin e.c = a; e.dz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.c = '0;
                else e.c = sa % sbv;
            end
`endif
            default: e.c = '0;
        endcase
        return e;
    endfunction

    // Monitor: everything the DUT presents is judged against the scoreboard.
    logic         seen = 1'b0;
    logic [W-1:0] held_c;
    logic         held_dz;
    always @(negedge i_clk) begin
        if (i_rst) begin
            seen = 1'b0;
        end else begin
            check("ready", o_ready, (sb.size() == 0));
            if (o_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", o_valid, 1'b0);
                end else begin
                    if (!seen) begin
                        check("latency", cyc - sb[0].acc_cyc + 1, sb[0].lat);
                        seen    = 1'b1;
                        held_c  = o_c;
                        held_dz = o_dz;
                    end else begin
                        check("hold_c", o_c, held_c);
                        check("hold_dz", o_dz, held_dz);
                    end
                    if (i_ready) begin
                        check($sformatf("c_op%02h", sb[0].op), o_c, sb[0].c);
                        check($sformatf("dz_op%02h", sb[0].op), o_dz, sb[0].dz);
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else if (seen) begin
                check("valid_held", o_valid, 1'b1);
            end
        end
    end

    // Issue one request, then wait for its result to be consumed while
    // throwing junk requests at the busy block. i_ready is held low for the
    // first 'hold' cycles, random afterwards.
    task automatic issue(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t e;
        int   k;
        @(posedge i_clk); #1;
        i_valid  = 1'b1;
        i_alu_op = op;
        i_a      = a;
        i_b      = b;
        k = 0;
        forever begin
            @(negedge i_clk);
            if (o_ready) break;
            k++;
            if (k > 60) begin
                check("accept_timeout", o_ready, 1'b1);
                i_valid = 1'b0;
                return;
            end
        end
        @(posedge i_clk); #1;
        e = model(op, a, b);
        e.acc_cyc = cyc;
        sb.push_back(e);
        k = 0;
        while (sb.size() != 0) begin
            if (k > 300) begin
                check("result_timeout", sb.size(), 0);
                sb.delete();
                break;
            end
            i_valid  = ($urandom_range(1, 0) == 1);
            i_alu_op = 8'($urandom);
            i_a      = $urandom;
            i_b      = $urandom;
            i_ready  = (k < hold) ? 1'b0 : ($urandom_range(2, 0) != 0);
            @(posedge i_clk); #1;
            k++;
        end
        i_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    vec_t dir[$] = '{
        '{8'h11, 32'hFFFF_FFFF, 32'h0000_0001},
        '{8'h31, 32'hFFFF_FFFF, 32'h0000_0001},
        '{8'h32, 32'hFFFF_FFFF, 32'h0000_0001},
        '{8'h35, 32'h8000_0000, 32'h0000_0004},
        '{8'h34, 32'h8000_0000, 32'h0000_0004},
        '{8'h33, 32'h0000_0003, 32'h0000_001F},
        '{8'h13, 32'h0001_0000, 32'h0001_0001},
        '{8'h14, 32'hFFFF_FFF9, 32'h0000_0002},
        '{8'h15, 32'hFFFF_FFF9, 32'h0000_0002},
        '{8'h14, 32'h0000_0005, 32'h0000_0000},
        '{8'h15, 32'hFFFF_FFFB, 32'h0000_0000},
        '{8'h14, 32'h8000_0000, 32'hFFFF_FFFF},
        '{8'h15, 32'h8000_0000, 32'hFFFF_FFFF},
        '{8'h13, 32'h0000_0003, 32'h0000_0004},
        '{8'h12, 32'h0000_0000, 32'h0000_0001},
        '{8'h24, 32'h0F0F_0000, 32'h0000_0000},
        '{8'h40, 32'h1234_5678, 32'h1111_1111},
        '{8'h00, 32'hDEAD_BEEF, 32'h1111_1111}
    };

    logic [7:0] codes [15] = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h21, 8'h22,
                               8'h23, 8'h24, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

    initial begin
        logic [7:0]   op;
        logic [W-1:0] a, b;
        exp_t         e;

        // Reset state.
        repeat (3) @(negedge i_clk);
        check("rst_ready", o_ready, 1'b1);
        check("rst_valid", o_valid, 1'b0);
        check("rst_c", o_c, 0);
        check("rst_dz", o_dz, 1'b0);
        #2 i_rst = 1'b0;

        foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, 0);

        // Result held for 10+ cycles in DONE with junk requests arriving.
        issue(8'h11, 32'h0000_1234, 32'h0000_0001, 12);

        // Randomized traffic.
        for (int n = 0; n < 120; n++) begin
            op = ($urandom_range(9, 0) == 0) ? 8'($urandom) : codes[$urandom_range(14, 0)];
            a  = ($urandom_range(7, 0) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(5, 0))
                0:       b = '0;
                1:       b = 32'($urandom_range(8, 1));
                2:       b = -32'($urandom_range(8, 1));
                default: b = $urandom;
            endcase
            issue(op, a, b, $urandom_range(3, 0));
        end

        // Abort a DIV at its 12th busy cycle (left in DONE when the
        // iterative unit is not built); o_c holds 0x1D from a prior op.
        issue(8'h11, 32'h0000_0010, 32'h0000_000D, 0);
        @(posedge i_clk); #1;
        i_ready  = 1'b0;
        i_valid  = 1'b1;
        i_alu_op = 8'h14;
        i_a      = 32'h7FFF_0000;
        i_b      = 32'h0000_0003;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        e = model(8'h14, 32'h7FFF_0000, 32'h0000_0003);
        e.acc_cyc = cyc;
        sb.push_back(e);
        repeat (11) @(posedge i_clk);
        @(negedge i_clk); #2;
        i_rst = 1'b1;
        sb.delete();
        #1;
        check("abort_valid", o_valid, 1'b0);
        check("abort_c", o_c, 0);
        check("abort_ready", o_ready, 1'b1);
        @(negedge i_clk);
        check("abort_valid_next", o_valid, 1'b0);
        check("abort_dz_next", o_dz, 1'b0);
        #2 i_rst = 1'b0;
        // Aborted op must never surface; the monitor flags any o_valid here.
        repeat (W + 8) @(posedge i_clk);
        issue(8'h11, 32'h0000_0002, 32'h0000_0003, 0);

        repeat (4) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from i_b[SHW-1:0].
REQ-003 i_clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 i_valid  input  1  request valid.
REQ-006 o_ready  output  1  block can accept a request.
REQ-007 i_alu_op  input  8  operation code, 4-bit class plus 4-bit sub-op.
REQ-008 i_a, i_b  input  WIDTH each  operands.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  consumer accepts result.
REQ-011 o_c  output  WIDTH  result.
REQ-012 o_dz  output  1  divide-by-zero flag, valid with o_valid.

Function
REQ-013 Codes SHALL be: NOP 0x00, ADD 0x11, SUB 0x12, MUL 0x13, DIV 0x14, MOD 0x15, AND 0x21, OR 0x22, XOR 0x23, INV 0x24, SLT 0x31, SLTU 0x32, SLL 0x33, SRL 0x34, SRA 0x35; any other code yields o_c=0.
REQ-014 States SHALL be IDLE, BUSY, DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-015 Accept occurs when i_valid&&o_ready; operands and op SHALL be registered at accept and ignored thereafter.
REQ-016 Non-iterative ops SHALL go IDLE->DONE at accept, result on o_c the next cycle (latency 1).
REQ-017 MUL/DIV/MOD SHALL go IDLE->BUSY, iterate exactly WIDTH cycles (one bit per cycle), then BUSY->DONE; latency WIDTH+1.
REQ-018 DONE SHALL hold o_c, o_dz, o_valid stable until i_ready=1, then go to IDLE; no accept in the same cycle.
REQ-019 Arithmetic modulo 2^WIDTH; ADD/SUB wrap, no carry/overflow output.
REQ-020 SLT signed, SLTU unsigned compare, result 1 or 0; SRA sign-fills, SRL/SLL zero-fill.
REQ-021 MUL SHALL return low WIDTH bits of the product.
REQ-022 DIV/MOD SHALL be signed, truncating toward zero; remainder takes dividend's sign.
REQ-023 Divisor 0: DIV returns all-ones, MOD returns i_a, o_dz=1; o_dz=0 for every other case.
REQ-024 Most-negative / -1: DIV returns i_a, MOD returns 0, o_dz=0.
REQ-025 i_valid while busy/done SHALL be ignored, not queued.

Reset
REQ-026 Reset SHALL force IDLE, o_ready=1, o_valid=0, o_c=0, o_dz=0, iteration counter 0, from any state incl. mid-iteration; an aborted op SHALL produce no result.

Configuration
REQ-027 Macro ALU_SEQ_MULDIV_EN: defined -> REQ-017/021-024 apply; undefined -> MUL/DIV/MOD take the non-iterative path, o_c=0, o_dz=0, and no iterative logic SHALL be synthesised.

Structure
REQ-028 Package alu_pkg SHALL hold the op-code constants and the state enum; alu_seq imports it.
REQ-029 Shift-add/restoring-division iteration SHALL live in sub-module alu_muldiv (start, done, WIDTH parameter), instanced only under ALU_SEQ_MULDIV_EN.

Verification (WIDTH=32)
REQ-030 ADD 0xFFFFFFFF+1 -> o_c=0 one cycle after accept; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-031 MUL 0x0001_0000*0x0001_0001 -> o_c=0x0001_0000, o_valid exactly 33 cycles after accept.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; MOD -7/2 -> 0xFFFFFFFF; DIV 5/0 -> 0xFFFFFFFF, o_dz=1; DIV 0x80000000/-1 -> 0x80000000.
REQ-033 Hold i_ready=0 for 10 cycles in DONE -> o_c/o_valid stable, o_ready=0, extra i_valid pulses dropped.
REQ-034 Assert i_rst at BUSY cycle 12 of a DIV -> next cycle IDLE, o_valid=0, o_c=0; following ADD 2+3 -> 5.
REQ-035 Build without ALU_SEQ_MULDIV_EN: MUL 3*4 -> o_c=0 after one cycle, o_dz=0.
